stage_fetch0: RTL and testbench

First instruction-fetch stage, directly upstream of fetch1. Owns the architectural fetch PC and selects the next PC from these sources, in priority order: CSR trap/return redirect, execute-stage branch redirect, branch-target-buffer (BTB) prediction, sequential increment. Presents the PC, a valid bit and a speculation-epoch bit (specid) to fetch1, and holds them while fetch1 stalls.

---
 rtl/stage_fetch0.sv | 119 +++++++++++
 tb/tb_stage_fetch0.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/stage_fetch0.sv
// stage_fetch0: first instruction-fetch stage. Owns the fetch PC and picks the
// next PC from CSR redirect, execute redirect, BTB prediction or PC+1.
// Optional feature macro: FETCH0_BTB_EN (direct-mapped BTB; absent by default).
module stage_fetch0 #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BTB_ENTRIES  = 16
) (
  input  logic        clk_core,
  input  logic        reset_n,
  output logic        fe0_valid,
  output logic        fe0_specid,
  output logic [29:0] fe0_read_addr,
  input  logic        fe1_stall,
  input  logic        ex_redirect,
  input  logic [29:0] ex_redirect_pc,
  input  logic        ex_btb_update,
  input  logic [29:0] ex_btb_pc,
  input  logic [29:0] ex_btb_target,
  input  logic        ex_btb_taken,
  input  logic        csr_redirect,
  input  logic [29:0] csr_redirect_pc,
  input  logic        csr_halt
);

  logic [29:0] r_pc;
  logic        r_specid;
  logic        r_valid;

  logic [29:0] w_pc_next;
  logic        w_specid_next;
  logic        w_adv;
  logic        w_btb_hit;
  logic [29:0] w_btb_target;

  // Halt masks the request directly so fetch stops in the same cycle halt rises.
  assign fe0_valid     = r_valid & ~csr_halt;
  assign fe0_read_addr = r_pc;
  assign fe0_specid    = r_specid;
  assign w_adv         = fe0_valid & ~fe1_stall;

`ifdef FETCH0_BTB_EN
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IW;

  logic          r_btb_valid [BTB_ENTRIES];
  logic [TW-1:0] r_btb_tag   [BTB_ENTRIES];
  logic [29:0]   r_btb_tgt   [BTB_ENTRIES];

  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_wr_idx;
  logic [TW-1:0] w_rd_tag;
  logic [TW-1:0] w_wr_tag;

  assign w_rd_idx     = r_pc[IW-1:0];
  assign w_rd_tag     = r_pc[29:IW];
  assign w_wr_idx     = ex_btb_pc[IW-1:0];
  assign w_wr_tag     = ex_btb_pc[29:IW];
  // Lookup reads current contents, so a same-cycle write is seen only next cycle.
  assign w_btb_hit    = r_btb_valid[w_rd_idx] && (r_btb_tag[w_rd_idx] == w_rd_tag);
  assign w_btb_target = r_btb_tgt[w_rd_idx];

  // Valid bits: set on taken update, cleared on not-taken update with matching tag.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb_valid[i] <= 1'b0;
    end else if (ex_btb_update) begin
      if (ex_btb_taken)
        r_btb_valid[w_wr_idx] <= 1'b1;
      else if (r_btb_tag[w_wr_idx] == w_wr_tag)
        r_btb_valid[w_wr_idx] <= 1'b0;
    end
  end

  // Tag/target storage is not reset; the valid bits guard it.
  always_ff @(posedge clk_core) begin
    if (ex_btb_update && ex_btb_taken) begin
      r_btb_tag[w_wr_idx] <= w_wr_tag;
      r_btb_tgt[w_wr_idx] <= ex_btb_target;
    end
  end
`else
  logic w_unused_btb;
  assign w_unused_btb = ^{ex_btb_update, ex_btb_pc, ex_btb_target, ex_btb_taken};
  assign w_btb_hit    = 1'b0;
  assign w_btb_target = '0;
`endif

  // Next-PC select: CSR redirect, execute redirect, BTB hit, sequential, hold.
  always_comb begin
    w_pc_next     = r_pc;
    w_specid_next = r_specid;
    if (csr_redirect) begin
      w_pc_next     = csr_redirect_pc;
      w_specid_next = ~r_specid;
    end else if (ex_redirect) begin
      w_pc_next     = ex_redirect_pc;
      w_specid_next = ~r_specid;
    end else if (w_adv && w_btb_hit) begin
      w_pc_next     = w_btb_target;
      w_specid_next = ~r_specid;
    end else if (w_adv) begin
      w_pc_next     = r_pc + 30'd1;
    end
  end

  // PC, epoch and valid registers; valid sets on the first edge out of reset.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_pc     <= RESET_VECTOR[31:2];
      r_specid <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_pc     <= w_pc_next;
      r_specid <= w_specid_next;
      r_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_fetch0.sv
// Directed testbench for stage_fetch0 (BTB expectations follow FETCH0_BTB_EN).
module tb_stage_fetch0;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        fe0_valid;
  logic        fe0_specid;
  logic [29:0] fe0_read_addr;
  logic        fe1_stall;
  logic        ex_redirect;
  logic [29:0] ex_redirect_pc;
  logic        ex_btb_update;
  logic [29:0] ex_btb_pc;
  logic [29:0] ex_btb_target;
  logic        ex_btb_taken;
  logic        csr_redirect;
  logic [29:0] csr_redirect_pc;
  logic        csr_halt;

  int n_total = 0;
  int n_bad   = 0;
  logic exp_spec = 1'b0;

  stage_fetch0 #(.RESET_VECTOR(32'h0000_1000), .BTB_ENTRIES(16)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .fe0_valid(fe0_valid), .fe0_specid(fe0_specid), .fe0_read_addr(fe0_read_addr),
    .fe1_stall(fe1_stall),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .ex_btb_update(ex_btb_update), .ex_btb_pc(ex_btb_pc),
    .ex_btb_target(ex_btb_target), .ex_btb_taken(ex_btb_taken),
    .csr_redirect(csr_redirect), .csr_redirect_pc(csr_redirect_pc),
    .csr_halt(csr_halt)
  );

  always #5 clk_core = ~clk_core;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Check all three outputs; address given as byte address.
  task automatic check_out(input string tag, input logic v, input logic [31:0] byte_addr, input logic s);
    check_val({tag, ".valid"}, {31'd0, fe0_valid}, {31'd0, v});
    check_val({tag, ".addr"},  {fe0_read_addr, 2'b00}, byte_addr);
    check_val({tag, ".spec"},  {31'd0, fe0_specid}, {31'd0, s});
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; fe1_stall = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0;
    ex_btb_update = 1'b0; ex_btb_pc = '0; ex_btb_target = '0; ex_btb_taken = 1'b0;
    csr_redirect = 1'b0; csr_redirect_pc = '0; csr_halt = 1'b0;

    tick(); tick();
    check_out("reset", 1'b0, 32'h1000, 1'b0);
    reset_n = 1'b1;
    tick(); check_out("run0", 1'b1, 32'h1000, 1'b0);
    tick(); check_out("run1", 1'b1, 32'h1004, 1'b0);
    tick(); check_out("run2", 1'b1, 32'h1008, 1'b0);

    // fetch1 stall for three cycles
    fe1_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_out("stall", 1'b1, 32'h1008, 1'b0);
    end
    fe1_stall = 1'b0;
    tick(); check_out("unstall", 1'b1, 32'h100C, 1'b0);

    // execute redirect while stalled
    fe1_stall = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 30'h800;
    exp_spec = ~exp_spec;
    tick(); check_out("exredir_stall", 1'b1, 32'h2000, exp_spec);
    ex_redirect = 1'b0;
    tick(); check_out("exredir_hold", 1'b1, 32'h2000, exp_spec);
    fe1_stall = 1'b0;
    tick(); check_out("exredir_next", 1'b1, 32'h2004, exp_spec);

    // simultaneous CSR and execute redirect: CSR wins, one toggle
    ex_redirect = 1'b1; ex_redirect_pc = 30'hC00;
    csr_redirect = 1'b1; csr_redirect_pc = 30'h040;
    exp_spec = ~exp_spec;
    tick(); check_out("both_redir", 1'b1, 32'h0100, exp_spec);
    ex_redirect = 1'b0; csr_redirect = 1'b0;
    tick(); check_out("both_next", 1'b1, 32'h0104, exp_spec);

    // halt for two cycles
    csr_halt = 1'b1;
    #1 check_out("halt_now", 1'b0, 32'h0104, exp_spec);
    tick(); check_out("halt1", 1'b0, 32'h0104, exp_spec);
    tick(); check_out("halt2", 1'b0, 32'h0104, exp_spec);
    csr_halt = 1'b0;
    #1 check_out("halt_rel", 1'b1, 32'h0104, exp_spec);
    tick(); check_out("halt_resume", 1'b1, 32'h0108, exp_spec);

    // redirect accepted during halt
    csr_halt = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 30'hC00;
    exp_spec = ~exp_spec;
    tick(); check_out("halt_redir", 1'b0, 32'h3000, exp_spec);
    ex_redirect = 1'b0;
    tick(); check_out("halt_redir_hold", 1'b0, 32'h3000, exp_spec);
    csr_halt = 1'b0;
    tick(); check_out("halt_redir_go", 1'b1, 32'h3004, exp_spec);

    // BTB: taken update for 0x1004 -> 0x1400 together with refetch of 0x1000
    ex_redirect = 1'b1; ex_redirect_pc = 30'h400;
    ex_btb_update = 1'b1; ex_btb_taken = 1'b1; ex_btb_pc = 30'h401; ex_btb_target = 30'h500;
    exp_spec = ~exp_spec;
    tick(); check_out("btb_refetch", 1'b1, 32'h1000, exp_spec);
    ex_redirect = 1'b0; ex_btb_update = 1'b0;
    tick(); check_out("btb_pre", 1'b1, 32'h1004, exp_spec);
`ifdef FETCH0_BTB_EN
    exp_spec = ~exp_spec;
    tick(); check_out("btb_hit", 1'b1, 32'h1400, exp_spec);
`else
    tick(); check_out("btb_off", 1'b1, 32'h1008, exp_spec);
`endif

    // not-taken update clears the entry; refetch 0x1000 again
    ex_redirect = 1'b1; ex_redirect_pc = 30'h400;
    ex_btb_update = 1'b1; ex_btb_taken = 1'b0; ex_btb_pc = 30'h401; ex_btb_target = 30'h0;
    exp_spec = ~exp_spec;
    tick(); check_out("nt_refetch", 1'b1, 32'h1000, exp_spec);
    ex_redirect = 1'b0; ex_btb_update = 1'b0;
    tick(); check_out("nt_pre", 1'b1, 32'h1004, exp_spec);
    tick(); check_out("nt_seq", 1'b1, 32'h1008, exp_spec);

    // 30-bit wrap of the sequential PC
    ex_redirect = 1'b1; ex_redirect_pc = 30'h3FFF_FFFF;
    exp_spec = ~exp_spec;
    tick(); check_out("wrap_top", 1'b1, 32'hFFFF_FFFC, exp_spec);
    ex_redirect = 1'b0;
    tick(); check_out("wrap_zero", 1'b1, 32'h0000_0000, exp_spec);

    // asynchronous reset mid-run
    #2 reset_n = 1'b0;
    #1 check_out("async_reset", 1'b0, 32'h1000, 1'b0);
    tick(); reset_n = 1'b1;
    tick(); check_out("rerun", 1'b1, 32'h1000, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
